// File: rtl/sram_rw_port_arbiter.sv
// Round-robin arbiter/sequencer for the RW port of a 1RW1R SRAM macro, with a post-reset zero-fill sweep.
// Latency: grant is combinational, read data returns READ_LAT cycles after the accepting edge.
// Backpressure: requesters hold req until gnt; no grants are issued while the init sweep runs.
module sram_rw_port_arbiter #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_WMASKS = 4,
    parameter int unsigned           READ_LAT   = 1,
    parameter bit                    INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [NUM_WMASKS-1:0] a_wmask,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [NUM_WMASKS-1:0] b_wmask,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  init_done
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  last_gnt_q, last_gnt_d;   // 1 = B won last
    logic [READ_LAT-1:0]   tag_vld_q, tag_id_q;      // id 1 = B
    logic                  rd_accept;

    // Every output is gated by rst_n so the macro sees an idle port for the whole reset window.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        last_gnt_d  = last_gnt_q;
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        init_done   = 1'b0;
        rd_accept   = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_INIT: begin
                    sram_csb0   = 1'b0;
                    sram_web0   = 1'b0;
                    sram_wmask0 = '1;
                    sram_addr0  = init_cnt_q;
                    sram_din0   = INIT_VALUE;
                    init_cnt_d  = init_cnt_q + ADDR_WIDTH'(1);
                    if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    init_done = 1'b1;
                    a_gnt     = a_req & (~b_req | last_gnt_q);
                    b_gnt     = b_req & ~a_gnt;
                    if (a_gnt) begin
                        sram_csb0   = 1'b0;
                        sram_web0   = ~a_we;
                        sram_wmask0 = a_we ? a_wmask : '0;
                        sram_addr0  = a_addr;
                        sram_din0   = a_wdata;
                    end else if (b_gnt) begin
                        sram_csb0   = 1'b0;
                        sram_web0   = ~b_we;
                        sram_wmask0 = b_we ? b_wmask : '0;
                        sram_addr0  = b_addr;
                        sram_din0   = b_wdata;
                    end
                    if (a_gnt || b_gnt) begin
                        last_gnt_d = b_gnt;
                    end
                    rd_accept = (a_gnt & ~a_we) | (b_gnt & ~b_we);
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT_EN ? S_INIT : S_RUN;
            init_cnt_q <= '0;
            last_gnt_q <= 1'b1;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            last_gnt_q   <= last_gnt_d;
            tag_vld_q[0] <= rd_accept;
            tag_id_q[0]  <= b_gnt;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    // The macro's dout is shared; the tag at the end of the pipe says whose it is.
    assign a_rvalid = tag_vld_q[READ_LAT-1] & ~tag_id_q[READ_LAT-1];
    assign b_rvalid = tag_vld_q[READ_LAT-1] &  tag_id_q[READ_LAT-1];
    assign a_rdata  = sram_dout0;
    assign b_rdata  = sram_dout0;

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Bench for sram_rw_port_arbiter: behavioural SRAM, a transaction-level reference model and directed scenarios.
module tb_sram_rw_port_arbiter;

    localparam int RL    = 1;
    localparam int DEPTH = 256;
    localparam logic [31:0] INITV = 32'h0;
    localparam logic [31:0] FILL  = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req, a_we, b_req, b_we;
    logic [3:0]  a_wmask, b_wmask;
    logic [7:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        sram_csb0, sram_web0, init_done;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0, sram_dout0;

    int n_total = 0;
    int n_pass  = 0;

    sram_rw_port_arbiter #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WMASKS(4),
        .READ_LAT(RL), .INIT_EN(1'b1), .INIT_VALUE(INITV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_wmask(a_wmask), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_wmask(b_wmask), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Behavioural macro: synchronous write with byte mask, read data after RL edges.
    logic [31:0] mem   [DEPTH];
    logic [31:0] dpipe [RL];
    assign sram_dout0 = dpipe[RL-1];

    always @(posedge clk) begin
        for (int i = RL - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int k = 0; k < 4; k++)
                    if (sram_wmask0[k]) mem[sram_addr0][8*k +: 8] <= sram_din0[8*k +: 8];
            end else begin
                dpipe[0] <= mem[sram_addr0];
            end
        end
    end

    // Reference model: cycle count since reset, last winner, golden memory, queue of pending returns.
    typedef struct {
        int          due;
        bit          id;
        logic [31:0] data;
    } ret_t;

    int          cyc;
    int          m_last;
    logic [31:0] gold [DEPTH];
    ret_t        rq[$];

    function automatic bit m_in_init();
        return cyc < DEPTH;
    endfunction

    function automatic int m_winner();
        if (m_in_init()) return -1;
        if (a_req && b_req) return (m_last == 0) ? 1 : 0;
        if (a_req) return 0;
        if (b_req) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int          w;
        bit          we;
        logic [3:0]  m;
        logic [7:0]  ad;
        logic [31:0] d;
        ret_t        r;
        if (!rst_n) begin
            cyc    = 0;
            m_last = 1;
            rq.delete();
        end else begin
            w = m_winner();
            if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
            if (m_in_init()) begin
                gold[cyc] = INITV;
            end else if (w >= 0) begin
                we = (w == 0) ? a_we    : b_we;
                m  = (w == 0) ? a_wmask : b_wmask;
                ad = (w == 0) ? a_addr  : b_addr;
                d  = (w == 0) ? a_wdata : b_wdata;
                if (we) begin
                    for (int k = 0; k < 4; k++)
                        if (m[k]) gold[ad][8*k +: 8] = d[8*k +: 8];
                end else begin
                    r.due  = cyc + RL;
                    r.id   = w[0];
                    r.data = gold[ad];
                    rq.push_back(r);
                end
                m_last = w;
            end
            cyc++;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        int          w;
        bit          ea, eb, ra, rb, we;
        logic [6:0]  exp_o;
        logic [43:0] exp_bus;
        if (!rst_n) begin
            exp_o   = 7'b0011000;
            exp_bus = '0;
        end else begin
            w  = m_winner();
            ea = (w == 0);
            eb = (w == 1);
            ra = rq.size() > 0 && rq[0].due == cyc && rq[0].id == 1'b0;
            rb = rq.size() > 0 && rq[0].due == cyc && rq[0].id == 1'b1;
            if (m_in_init()) begin
                exp_o   = {2'b00, 2'b00, 1'b0, ra, rb};
                exp_bus = {cyc[7:0], 4'hF, INITV};
            end else if (w >= 0) begin
                we      = ea ? a_we : b_we;
                exp_o   = {ea, eb, 1'b0, ~we, 1'b1, ra, rb};
                exp_bus = {ea ? a_addr : b_addr, we ? (ea ? a_wmask : b_wmask) : 4'h0, ea ? a_wdata : b_wdata};
            end else begin
                exp_o   = {2'b00, 2'b11, 1'b1, ra, rb};
                exp_bus = '0;
            end
            if (ra) check("a_rdata", a_rdata, rq[0].data);
            if (rb) check("b_rdata", b_rdata, rq[0].data);
        end
        check("outputs{gnt,csb,web,done,rvalid}", {a_gnt, b_gnt, sram_csb0, sram_web0, init_done, a_rvalid, b_rvalid}, exp_o);
        check("sram_bus{addr,wmask,din}", {sram_addr0, sram_wmask0, sram_din0}, exp_bus);
    end

    // Issue one access and hold it until granted; returns one unit after the accepting edge.
    task automatic access(input bit id, input bit we, input logic [3:0] m, input logic [7:0] ad, input logic [31:0] d);
        bit got;
        got = 1'b0;
        if (id == 0) begin a_req = 1; a_we = we; a_wmask = m; a_addr = ad; a_wdata = d; end
        else         begin b_req = 1; b_we = we; b_wmask = m; b_addr = ad; b_wdata = d; end
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = (id == 0) ? a_gnt : b_gnt;
        end
        check("gnt_wait", got, 1'b1);
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
    endtask

    task automatic read_get(input bit id, input logic [7:0] ad, output logic [31:0] d, output int lat);
        bit got;
        access(id, 1'b0, 4'h0, ad, 32'h0);
        got = 1'b0;
        lat = 0;
        d   = 'x;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            lat++;
            got = (id == 0) ? a_rvalid : b_rvalid;
            d   = (id == 0) ? a_rdata  : b_rdata;
        end
        check("rvalid_wait", got, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (init_done) break;
            n++;
        end
    endtask

    initial begin
        logic [31:0] d;
        int          lat, n, rv_cnt, rv_seen;
        logic [7:0]  gseq, rseq;
        bit          gnt_seen;
        for (int i = 0; i < DEPTH; i++) begin mem[i] = FILL; gold[i] = FILL; end
        for (int i = 0; i < RL; i++) dpipe[i] = '0;
        a_req = 0; a_we = 0; a_wmask = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_wmask = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;

        // Sweep: 256 write cycles, a held request is refused until the sweep ends.
        a_req = 1; a_we = 0; a_addr = 8'h05;
        n = 0; gnt_seen = 0;
        while (n < 400) begin
            @(negedge clk);
            if (init_done) break;
            gnt_seen |= a_gnt | b_gnt;
            n++;
        end
        check("init_cycles", n, 256);
        check("gnt_during_init", gnt_seen, 1'b0);
        check("first_run_gnt", a_gnt, 1'b1);
        @(posedge clk); #1 a_req = 0;
        @(posedge clk); #1;

        // Write then read-after-write in consecutive cycles.
        access(0, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
        read_get(0, 8'h10, d, lat);
        check("raw_data", d, 32'hDEADBEEF);
        check("read_latency", lat, RL);
        // A write with an all-zero mask changes nothing.
        access(0, 1'b1, 4'h0, 8'h10, 32'h12345678);
        read_get(0, 8'h10, d, lat);
        check("zero_mask_write", d, 32'hDEADBEEF);

        // Partial byte write.
        access(1, 1'b1, 4'hF, 8'h20, 32'hFFFFFFFF);
        access(1, 1'b1, 4'b0101, 8'h20, 32'h11223344);
        read_get(1, 8'h20, d, lat);
        check("masked_write", d, 32'hFF22FF44);

        // Contention: B won last, so A, B, A, B ... and returns in the same order.
        access(0, 1'b1, 4'hF, 8'h01, 32'h0000_0A01);
        access(1, 1'b1, 4'hF, 8'h02, 32'h0000_0B02);
        a_req = 1; a_we = 0; a_addr = 8'h01;
        b_req = 1; b_we = 0; b_addr = 8'h02;
        gseq = '0; rseq = '0; rv_cnt = 0; n = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i < 8) begin
                gseq[i] = b_gnt;
                n += int'(a_gnt) + int'(b_gnt);
            end
            if (i >= 1) begin
                rseq[i-1] = b_rvalid;
                rv_cnt += int'(a_rvalid | b_rvalid);
            end
            if (i == 7) begin @(posedge clk); #1 a_req = 0; b_req = 0; end
        end
        check("contention_gnt_seq", gseq, 8'b10101010);
        check("contention_gnt_count", n, 8);
        check("contention_rvalid_seq", rseq, 8'b10101010);
        check("contention_rvalid_count", rv_cnt, 8);
        @(posedge clk); #1;

        // Reset in the middle of the sweep restarts it from address 0.
        rst_n = 0;
        @(posedge clk); #2 rst_n = 1;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (sram_addr0 == 8'd100) break;
            n++;
        end
        check("sweep_reaches_100", sram_addr0, 8'd100);
        #1 rst_n = 0;
        #1 check("csb_in_reset", sram_csb0, 1'b1);
        @(posedge clk); #2 rst_n = 1;
        @(negedge clk);
        check("sweep_restart_addr", sram_addr0, 8'd0);
        check("sweep_restart_csb", sram_csb0, 1'b0);
        wait_init(n);
        check("init_cycles_after_reset", n, 255);
        @(posedge clk); #1;

        // A read in flight is dropped by reset, and B is the reset value of the last winner.
        access(0, 1'b0, 4'h0, 8'h10, 32'h0);
        rst_n = 0;
        rv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rv_seen += int'(a_rvalid | b_rvalid);
            if (i == 1) begin @(posedge clk); #2 rst_n = 1; end
        end
        check("dropped_read_rvalid", rv_seen, 0);
        wait_init(n);
        @(posedge clk); #1;
        a_req = 1; a_we = 0; a_addr = 8'h03;
        b_req = 1; b_we = 0; b_addr = 8'h04;
        @(negedge clk);
        check("post_reset_a_wins", {a_gnt, b_gnt}, 2'b10);
        @(posedge clk); #1 a_req = 0; b_req = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
